// File: rtl/decode_issue_scoreboard_pkg.sv
// Shared types for the decode/issue scoreboard: the per-stage entry record and
// the forward-select encoding shared by the top and the operand checkers.
package decode_issue_scoreboard_pkg;

   localparam int DEF_NUM_REGS   = 32;
   localparam int DEF_DEPTH      = 3;
   localparam int DEF_ALU_AVAIL  = 2;
   localparam int DEF_LOAD_AVAIL = 3;

   // Storage widths are fixed at the upper bound so the entry struct can live
   // here; narrower register indices and selects are zero-extended into them.
   localparam int MAX_IDX_W = 8;
   localparam int MAX_SEL_W = 4;

   typedef logic [MAX_SEL_W-1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_REGFILE = '0;

   typedef struct packed {
      logic                 valid;
      logic [MAX_IDX_W-1:0] rd;
      logic                 is_load;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

   // Writers that never produce a visible result are stored invalid so that
   // they can never match a consumer.
   function automatic sb_entry_t make_entry(input logic                 reg_write,
                                            input logic [MAX_IDX_W-1:0] rd,
                                            input logic                 is_load);
      sb_entry_t e;
      e.valid   = reg_write && (rd != '0);
      e.rd      = rd;
      e.is_load = is_load;
      return e;
   endfunction

endpackage

// File: rtl/decode_issue_scoreboard_operand_check.sv
// One source operand checked against the in-flight writers: reports a hazard
// or names the stage the consumer must forward from once it reaches execute.
module sb_operand_check
   import decode_issue_scoreboard_pkg::*;
#(
   parameter int IDX_W      = 5,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ALU_AVAIL  = DEF_ALU_AVAIL,
   parameter int LOAD_AVAIL = DEF_LOAD_AVAIL
) (
   input  logic                    [IDX_W-1:0] src,
   input  logic                                src_used,
   input  sb_entry_t [DEPTH:1]                 sb,
   output logic                                hazard,
   output fwd_sel_t                            fwd_sel
);

   logic [MAX_IDX_W-1:0] src_ext;
   assign src_ext = MAX_IDX_W'(src);

   // Walk oldest to youngest so the youngest matching writer overwrites the
   // result. Entry DEPTH is excluded: it writes the register file this cycle.
   always_comb begin
      // NOTE: every output gets a default before the loop; an output left
      // unassigned on some path would infer a latch.
      hazard  = 1'b0;
      fwd_sel = FWD_REGFILE;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (src_used && (src_ext != '0) && sb[k].valid && (sb[k].rd == src_ext)) begin
            if ((k + 1) < (sb[k].is_load ? LOAD_AVAIL : ALU_AVAIL)) begin
               hazard  = 1'b1;
               fwd_sel = FWD_REGFILE;
            end else begin
               hazard  = 1'b0;
               fwd_sel = fwd_sel_t'(k + 1);
            end
         end
      end
   end

endmodule

// File: rtl/decode_issue_scoreboard.sv
// Issue gate between decode and execute: tracks in-flight writers, stalls on
// operand hazards, and issues forwarding selects with a ready/valid handshake.
module decode_issue_scoreboard
   import decode_issue_scoreboard_pkg::*;
#(
   parameter int NUM_REGS     = DEF_NUM_REGS,
   parameter int IDX_W        = $clog2(NUM_REGS),
   parameter int DEPTH        = DEF_DEPTH,
   parameter int ALU_AVAIL    = DEF_ALU_AVAIL,
   parameter int LOAD_AVAIL   = DEF_LOAD_AVAIL,
   parameter int FLUSH_STAGES = 1,
   parameter int SEL_W        = $clog2(DEPTH + 1),
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_rs1,
   input  logic [IDX_W-1:0] in_rs2,
   input  logic             in_rs1_used,
   input  logic             in_rs2_used,
   input  logic [IDX_W-1:0] in_rd,
   input  logic             in_reg_write,
   input  logic             in_is_load,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_rd,
   output logic             out_reg_write,
   output logic [SEL_W-1:0] out_fwd1_sel,
   output logic [SEL_W-1:0] out_fwd2_sel,
   output logic [CNT_W-1:0] stall_count_out
);

   sb_entry_t [DEPTH:1] sb_q;
   sb_entry_t [DEPTH:1] sb_live;
   sb_entry_t [DEPTH:1] sb_d;

   logic     hazard1;
   logic     hazard2;
   logic     hazard;
   logic     issue;
   logic     stall_inc;
   fwd_sel_t sel1;
   fwd_sel_t sel2;

   sb_operand_check #(
      .IDX_W      (IDX_W),
      .DEPTH      (DEPTH),
      .ALU_AVAIL  (ALU_AVAIL),
      .LOAD_AVAIL (LOAD_AVAIL)
   ) u_check_rs1 (
      .src      (in_rs1),
      .src_used (in_rs1_used),
      .sb       (sb_q),
      .hazard   (hazard1),
      .fwd_sel  (sel1)
   );

   sb_operand_check #(
      .IDX_W      (IDX_W),
      .DEPTH      (DEPTH),
      .ALU_AVAIL  (ALU_AVAIL),
      .LOAD_AVAIL (LOAD_AVAIL)
   ) u_check_rs2 (
      .src      (in_rs2),
      .src_used (in_rs2_used),
      .sb       (sb_q),
      .hazard   (hazard2),
      .fwd_sel  (sel2)
   );

   assign hazard    = hazard1 | hazard2;
   assign in_ready  = out_ready & ~hazard & ~flush;
   assign issue     = in_valid & in_ready;
   assign stall_inc = in_valid & out_ready & hazard & ~flush;

   // Flushed instructions are killed before the shift, so they never advance
   // into an older stage and cannot be matched again on the next cycle.
   always_comb begin
      sb_live = sb_q;
      if (flush) begin
         for (int k = 1; k <= DEPTH; k++) begin
            if (k <= FLUSH_STAGES) sb_live[k].valid = 1'b0;
         end
      end

      sb_d = sb_live;
      if (out_ready) begin
         for (int k = DEPTH; k >= 2; k--) sb_d[k] = sb_live[k-1];
         sb_d[1] = issue ? make_entry(in_reg_write, MAX_IDX_W'(in_rd), in_is_load) : SB_EMPTY;
      end
   end

   // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset
   // along with everything else; stale valid bits would cause false stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_q <= '0;
      end else begin
         // NOTE: sequential state is updated only with non-blocking assignments
         // so every flop samples pre-edge values regardless of statement order.
         sb_q <= sb_d;
      end
   end

   // Output register: loads on advance, and also on flush so the killed
   // stage-1 instruction is replaced by a bubble even under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         out_fwd1_sel  <= '0;
         out_fwd2_sel  <= '0;
      end else if (out_ready || flush) begin
         if (issue) begin
            out_valid     <= 1'b1;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
            out_fwd1_sel  <= SEL_W'(sel1);
            out_fwd2_sel  <= SEL_W'(sel2);
         end else begin
            out_valid     <= 1'b0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_fwd1_sel  <= '0;
            out_fwd2_sel  <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_out <= '0;
      end else if (stall_inc && (stall_count_out != '1)) begin
         stall_count_out <= stall_count_out + 1'b1;
      end
   end

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// Directed bench for decode_issue_scoreboard: a table of per-cycle vectors plus
// hand sequences for counter saturation and asynchronous reset.
module tb_decode_issue_scoreboard;

   localparam int IDX_W = 5;
   localparam int SEL_W = 2;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_rs1;
   logic [IDX_W-1:0] in_rs2;
   logic             in_rs1_used;
   logic             in_rs2_used;
   logic [IDX_W-1:0] in_rd;
   logic             in_reg_write;
   logic             in_is_load;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_rd;
   logic             out_reg_write;
   logic [SEL_W-1:0] out_fwd1_sel;
   logic [SEL_W-1:0] out_fwd2_sel;
   logic [CNT_W-1:0] stall_count_out;

   int checks   = 0;
   int failures = 0;

   decode_issue_scoreboard #(
      .NUM_REGS (32),
      .CNT_W    (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_rs1          (in_rs1),
      .in_rs2          (in_rs2),
      .in_rs1_used     (in_rs1_used),
      .in_rs2_used     (in_rs2_used),
      .in_rd           (in_rd),
      .in_reg_write    (in_reg_write),
      .in_is_load      (in_is_load),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_rd          (out_rd),
      .out_reg_write   (out_reg_write),
      .out_fwd1_sel    (out_fwd1_sel),
      .out_fwd2_sel    (out_fwd2_sel),
      .stall_count_out (stall_count_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       ld;
      logic       fl;
      logic       ordy;
      logic       e_in_ready;
      logic       e_valid;
      logic [4:0] e_rd;
      logic       e_rw;
      logic [1:0] e_s1;
      logic [1:0] e_s2;
      logic [3:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic valid, input int rs1, input logic u1,
                               input int rs2, input logic u2, input int rd,
                               input logic rw, input logic ld, input logic fl,
                               input logic ordy, input logic er, input logic ev,
                               input int erd, input logic erw, input int s1,
                               input int s2, input int cnt);
      vec_t v;
      v.valid = valid; v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
      v.rd = 5'(rd); v.rw = rw; v.ld = ld; v.fl = fl; v.ordy = ordy;
      v.e_in_ready = er; v.e_valid = ev; v.e_rd = 5'(erd); v.e_rw = erw;
      v.e_s1 = 2'(s1); v.e_s2 = 2'(s2); v.e_cnt = 4'(cnt);
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic valid, input int rs1, input logic u1,
                        input int rs2, input logic u2, input int rd, input logic rw,
                        input logic ld, input logic fl, input logic ordy);
      in_valid = valid; in_rs1 = 5'(rs1); in_rs1_used = u1; in_rs2 = 5'(rs2);
      in_rs2_used = u2; in_rd = 5'(rd); in_reg_write = rw; in_is_load = ld;
      flush = fl; out_ready = ordy;
   endtask

   task automatic check_outs(input int idx, input logic ev, input int erd, input logic erw,
                             input int s1, input int s2, input int cnt);
      check("out_valid", idx, 32'(out_valid), 32'(ev));
      check("out_rd", idx, 32'(out_rd), 32'(erd));
      check("out_reg_write", idx, 32'(out_reg_write), 32'(erw));
      check("out_fwd1_sel", idx, 32'(out_fwd1_sel), 32'(s1));
      check("out_fwd2_sel", idx, 32'(out_fwd2_sel), 32'(s2));
      check("stall_count", idx, 32'(stall_count_out), 32'(cnt));
   endtask

   localparam int NV = 24;
   vec_t vecs [NV];
   int   exp_cnt;

   initial begin
      // valid rs1 u1 rs2 u2 rd rw ld fl ordy | in_rdy val rd rw s1 s2 cnt
      vecs[0]  = mk(1, 0,0, 0,0,  5,1,0,0,1,  1,1, 5,1,0,0,0); // write x5
      vecs[1]  = mk(1, 5,1, 0,0, 10,1,0,0,1,  1,1,10,1,2,0,0); // ALU back-to-back
      vecs[2]  = mk(1, 5,1, 0,0,  6,1,1,0,1,  1,1, 6,1,3,0,0); // load x6, x5 from stage 3
      vecs[3]  = mk(1, 0,0, 6,1, 11,1,0,0,1,  0,0, 0,0,0,0,1); // load-use stall
      vecs[4]  = mk(1, 0,0, 6,1, 11,1,0,0,1,  1,1,11,1,0,3,1); // reissue, sel 3
      vecs[5]  = mk(1, 0,0, 0,0,  7,1,0,0,1,  1,1, 7,1,0,0,1); // x7 older writer
      vecs[6]  = mk(1, 0,0, 0,0,  7,1,0,0,1,  1,1, 7,1,0,0,1); // x7 younger writer
      vecs[7]  = mk(1, 7,1,11,1, 12,1,0,0,1,  1,1,12,1,2,0,1); // youngest wins; x11 at WB
      vecs[8]  = mk(1, 0,0, 0,0,  0,1,0,0,1,  1,1, 0,1,0,0,1); // rd=0 writer
      vecs[9]  = mk(1, 0,1, 0,1, 13,0,0,0,1,  1,1,13,0,0,0,1); // read x0 twice
      vecs[10] = mk(1, 0,0, 0,0,  9,1,1,0,1,  1,1, 9,1,0,0,1); // load x9
      vecs[11] = mk(1, 9,0, 9,0, 14,1,0,0,1,  1,1,14,1,0,0,1); // unused sources
      vecs[12] = mk(1,14,1, 9,1, 15,1,0,0,0,  0,1,14,1,0,0,1); // back-pressure x3
      vecs[13] = mk(1,14,1, 9,1, 15,1,0,0,0,  0,1,14,1,0,0,1);
      vecs[14] = mk(1,14,1, 9,1, 15,1,0,0,0,  0,1,14,1,0,0,1);
      vecs[15] = mk(1,14,1, 9,1, 15,1,0,0,1,  1,1,15,1,2,3,1); // release
      vecs[16] = mk(1, 0,0, 0,0,  8,1,1,0,1,  1,1, 8,1,0,0,1); // load x8
      vecs[17] = mk(1, 8,1, 0,0, 16,1,0,1,1,  0,0, 0,0,0,0,1); // flush: no stall count
      vecs[18] = mk(1, 8,1, 0,0, 16,1,0,0,1,  1,1,16,1,0,0,1); // reissue from regfile
      vecs[19] = mk(1, 0,0, 0,0, 17,1,0,1,0,  0,0, 0,0,0,0,1); // flush under back-pressure
      vecs[20] = mk(1,16,1, 0,0, 18,1,0,0,1,  1,1,18,1,0,0,1); // x16 was killed
      vecs[21] = mk(0,18,1, 0,0, 19,1,0,0,1,  1,0, 0,0,0,0,1); // idle -> bubble
      vecs[22] = mk(1, 0,0, 0,0, 19,1,1,0,1,  1,1,19,1,0,0,1); // load x19
      vecs[23] = mk(0,19,1, 0,0, 20,1,0,0,1,  0,0, 0,0,0,0,1); // hazard w/o valid: no count

      rst_n = 1'b0;
      drive(0, 0,0, 0,0, 0,0,0,0,1);
      #2;
      check_outs(-1, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].valid, int'(vecs[i].rs1), vecs[i].u1, int'(vecs[i].rs2), vecs[i].u2,
               int'(vecs[i].rd), vecs[i].rw, vecs[i].ld, vecs[i].fl, vecs[i].ordy);
         #1;
         check("in_ready", i, 32'(in_ready), 32'(vecs[i].e_in_ready));
         @(posedge clk);
         #1;
         check_outs(i, vecs[i].e_valid, int'(vecs[i].e_rd), vecs[i].e_rw,
                    int'(vecs[i].e_s1), int'(vecs[i].e_s2), int'(vecs[i].e_cnt));
      end

      // Repeated load-use stalls drive the counter into saturation.
      exp_cnt = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(1, 0,0, 0,0, 20,1,1,0,1);
         @(negedge clk);
         drive(1, 20,1, 0,0, 21,1,0,0,1);
         #1;
         check("sat_in_ready_stall", i, 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
         check("sat_count", i, 32'(stall_count_out), 32'(exp_cnt));
         @(negedge clk);
         #1;
         check("sat_in_ready_issue", i, 32'(in_ready), 32'd1);
         @(posedge clk);
         #1;
         check("sat_fwd1", i, 32'(out_fwd1_sel), 32'd3);
      end
      check("sat_final", 0, 32'(stall_count_out), 32'd15);

      // Asynchronous reset between edges with a load in flight.
      @(negedge clk);
      drive(1, 0,0, 0,0, 22,1,1,0,1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs(100, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 22,1, 0,0, 23,1,0,0,1);
      #1;
      check("rst_in_ready", 101, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check_outs(101, 1, 23, 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_issue_scoreboard.md
Name: decode_issue_scoreboard

Overview:
Parametrised successor to the decode-stage hazard logic: the issue gate between decode and execute. It tracks every in-flight register writer in a DEPTH-entry shift scoreboard, stalls only when a source operand is not yet available, and otherwise issues one forwarding select per operand naming the producing stage. Ready/valid handshakes on both sides replace the single stall wire. Adds per-type result latency, flush of younger stages and a saturating hazard-stall counter.

Parameters:
NUM_REGS, 32, architectural register count; register 0 is hard-wired zero
IDX_W, $clog2(NUM_REGS), register index width
DEPTH, 3, scoreboard stages tracked after issue (1 = EX … DEPTH = WB)
ALU_AVAIL, 2, first stage index whose ALU result may be forwarded
LOAD_AVAIL, 3, first stage index whose load result may be forwarded (LOAD_AVAIL >= ALU_AVAIL, <= DEPTH)
FLUSH_STAGES, 1, stages 1..FLUSH_STAGES cleared by flush
SEL_W, $clog2(DEPTH+1), forward-select width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle
in_rs1 / in_rs2  in  IDX_W  source indices
in_rs1_used / in_rs2_used  in  1  source actually read (PC/imm operands: 0)
in_rd  in  IDX_W  destination index
in_reg_write  in  1  instruction writes rd
in_is_load  in  1  result from memory
flush  in  1  kill input instruction and young stages
out_valid  out  1  registered issue valid to execute
out_ready  in  1  execute accepts / pipeline advances
out_rd  out  IDX_W  registered destination
out_reg_write  out  1  registered write enable
out_fwd1_sel / out_fwd2_sel  out  SEL_W  0 = register file, k = forward from stage k
stall_count_out  out  CNT_W  cycles lost to operand hazards

Behaviour:
- Reset (async, rst_n=0): all scoreboard entries invalid; out_valid=0, out_rd=0, out_reg_write=0, fwd sels=0, stall_count_out=0. Reset mid-operation discards everything in flight.
- Scoreboard entry k (1..DEPTH): {valid, rd, is_load}; entry 1 mirrors the output register. Entries with rd=0 or reg_write=0 are stored invalid.
- Advance: when out_ready=1, entry k <= entry k-1 for k>=2; entry 1 <= issued instruction or bubble. When out_ready=0 everything holds, including outputs.
- Per used source s (s != 0): search entries 1..DEPTH-1, youngest (lowest k) matching valid entry wins. Producer will be at k+1 when consumer is in EX. avail = LOAD_AVAIL if is_load else ALU_AVAIL.
  - k+1 < avail -> hazard.
  - otherwise fwd_sel = k+1.
  - no match (or only entry DEPTH, written this cycle, register file write-through) -> fwd_sel = 0.
- Unused sources and source 0: never hazard, sel 0.
- in_ready = out_ready & ~hazard & ~flush. Issue = in_valid & in_ready.
- On advance without issue: entry 1 is bubble (out_valid=0, out_reg_write=0, sels 0).
- stall_count_out increments (saturating at all-ones) each cycle in_valid & out_ready & hazard & ~flush; not on back-pressure or flush.
- flush=1: entries 1..FLUSH_STAGES invalidated (out_valid/out_reg_write cleared) at the clock edge regardless of out_ready; input not issued. Older entries still advance if out_ready. Flush has priority over issue; hazards against flushed entries are ignored that cycle.
- Latency: issue to out_valid = 1 cycle. Zero-hazard throughput 1/cycle.

Decomposition:
- Shared package: scoreboard entry struct, forward-select typedef, FWD_REGFILE=0 constant, default DEPTH/AVAIL constants.
- One sub-module: sb_operand_check (one source vs scoreboard -> hazard, fwd_sel), instantiated twice.

Test Plan:
- ALU back-to-back: write x5, next cycle read rs1=x5 -> no stall, out_fwd1_sel=2, stall_count 0.
- Load-use: load x6 then rs2=x6 -> in_ready=0 one cycle, bubble issued, then out_fwd2_sel=3, stall_count=1.
- Youngest wins: two consecutive writes to x7 then read x7 -> sel=2; rd=0 writer then read x0 -> sel 0, no stall.
- Back-pressure: out_ready=0 for 3 cycles with valid input -> outputs/scoreboard frozen, in_ready=0, stall_count unchanged.
- Flush: load x8 in stage 1, consumer of x8 at input, flush=1 -> stage 1 cleared, consumer not issued, next-cycle reissue sel=0 without stall.
- Async reset asserted mid-stream between edges -> outputs 0 immediately; after release first instruction issues with sels 0.
